// File: rtl/mem_stage_if.sv
// Signals between EXE, the MEM stage, WB, decode and the data SRAM response channel.
// The slave modport is the MEM stage's view; master is the surrounding pipeline's view.
interface mem_stage_if #(
    parameter int unsigned EXE_TO_MEM_BUS_WD = 78,
    parameter int unsigned CSR_BUS_WD        = 96,
    parameter int unsigned MEM_TO_WB_BUS_WD  = 70
);
    logic                         exe_to_mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus;
    logic [CSR_BUS_WD-1:0]        exe_to_mem_csr_bus;
    logic                         exe_to_mem_req;
    logic                         mem_allowin;
    logic                         wb_allowin;
    logic                         wb_flush;
    logic                         data_sram_data_ok;
    logic [31:0]                  data_sram_rdata;
    logic                         mem_to_wb_valid;
    logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus;
    logic [CSR_BUS_WD-1:0]        mem_to_wb_csr_bus;
    logic                         mem_ex_out;
    logic                         gr_we_mem;
    logic [4:0]                   dest_mem;
    logic [31:0]                  forward_data_mem;
    logic                         mem_load_pending;

    modport slave (
        input  exe_to_mem_valid,
        input  exe_to_mem_bus,
        input  exe_to_mem_csr_bus,
        input  exe_to_mem_req,
        input  wb_allowin,
        input  wb_flush,
        input  data_sram_data_ok,
        input  data_sram_rdata,
        output mem_allowin,
        output mem_to_wb_valid,
        output mem_to_wb_bus,
        output mem_to_wb_csr_bus,
        output mem_ex_out,
        output gr_we_mem,
        output dest_mem,
        output forward_data_mem,
        output mem_load_pending
    );

    modport master (
        output exe_to_mem_valid,
        output exe_to_mem_bus,
        output exe_to_mem_csr_bus,
        output exe_to_mem_req,
        output wb_allowin,
        output wb_flush,
        output data_sram_data_ok,
        output data_sram_rdata,
        input  mem_allowin,
        input  mem_to_wb_valid,
        input  mem_to_wb_bus,
        input  mem_to_wb_csr_bus,
        input  mem_ex_out,
        input  gr_we_mem,
        input  dest_mem,
        input  forward_data_mem,
        input  mem_load_pending
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, waits for its data-SRAM response,
// extracts load data for WB and decode, and drops responses orphaned by a WB flush.
module mem_stage #(
    parameter int unsigned EXE_TO_MEM_BUS_WD = 78,
    parameter int unsigned CSR_BUS_WD        = 96,
    parameter int unsigned MEM_TO_WB_BUS_WD  = 70
) (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave mem_if
);

    typedef enum logic [1:0] {StEmpty, StWait, StReady} state_e;

    state_e                       state_q, state_d;
    logic [EXE_TO_MEM_BUS_WD-1:0] bus_q;
    logic [CSR_BUS_WD-1:0]        csr_q;
    logic [31:0]                  data_buf_q, data_buf_d;
    logic [1:0]                   discard_q, discard_d;

    logic        valid;
    logic        data_hit;
    logic        data_drop;
    logic        mem_ready_go;
    logic        mem_allowin;
    logic        accept;
    logic        orphan;

    logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
    logic        signed_option, lu12i_w;
    logic        load_op, gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc;

    logic [31:0] rdata_src;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] extracted;
    logic [31:0] final_result;
    logic [MEM_TO_WB_BUS_WD-1:0] wb_bus;
    logic        unused_bits;

    assign ld_b          = bus_q[77];
    assign ld_bu         = bus_q[76];
    assign ld_h          = bus_q[75];
    assign ld_hu         = bus_q[74];
    assign ld_w          = bus_q[73];
    assign signed_option = bus_q[72];
    assign lu12i_w       = bus_q[71];
    assign load_op       = bus_q[70];
    assign gr_we         = bus_q[69];
    assign dest          = bus_q[68:64];
    assign alu_result    = bus_q[63:32];
    assign pc            = bus_q[31:0];

    // Sign is implied by the load kind; the remaining decode bits are informational here.
    assign unused_bits = ^{signed_option, lu12i_w, ld_w};

    assign valid = (state_q != StEmpty);

    // A response belongs to the held instruction only when no orphans are still in flight.
    assign data_hit  = mem_if.data_sram_data_ok & (discard_q == 2'd0);
    assign data_drop = mem_if.data_sram_data_ok & (discard_q != 2'd0);

    assign mem_ready_go = (state_q == StReady) | ((state_q == StWait) & data_hit);
    assign mem_allowin  = ~valid | (mem_ready_go & mem_if.wb_allowin);
    assign accept       = mem_if.exe_to_mem_valid & mem_allowin & ~mem_if.wb_flush;
    assign orphan       = mem_if.wb_flush & (state_q == StWait) & ~data_hit;

    always_comb begin
        rdata_src = (state_q == StReady) ? data_buf_q : mem_if.data_sram_rdata;
        load_byte = rdata_src[{alu_result[1:0], 3'b000} +: 8];
        load_half = alu_result[1] ? rdata_src[31:16] : rdata_src[15:0];
        if (ld_b) begin
            extracted = {{24{load_byte[7]}}, load_byte};
        end else if (ld_bu) begin
            extracted = {24'd0, load_byte};
        end else if (ld_h) begin
            extracted = {{16{load_half[15]}}, load_half};
        end else if (ld_hu) begin
            extracted = {16'd0, load_half};
        end else begin
            extracted = rdata_src;
        end
        final_result = load_op ? extracted : alu_result;
    end

    always_comb begin
        state_d    = state_q;
        data_buf_d = data_buf_q;
        if (mem_if.wb_flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            state_d = mem_if.exe_to_mem_req ? StWait : StReady;
        end else if ((state_q == StWait) & data_hit & ~mem_if.wb_allowin) begin
            // WB is stalled: park the response so the SRAM channel is free.
            state_d    = StReady;
            data_buf_d = mem_if.data_sram_rdata;
        end else if (mem_ready_go & mem_if.wb_allowin) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        discard_d = discard_q;
        case ({orphan, data_drop})
            2'b10: begin
                if (discard_q != 2'd3) begin
                    discard_d = discard_q + 2'd1;
                end
            end
            2'b01:   discard_d = discard_q - 2'd1;
            default: discard_d = discard_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StEmpty;
            bus_q      <= '0;
            csr_q      <= '0;
            data_buf_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_buf_q <= data_buf_d;
            discard_q  <= discard_d;
            if (accept) begin
                bus_q <= mem_if.exe_to_mem_bus;
                csr_q <= mem_if.exe_to_mem_csr_bus;
            end
        end
    end

    assign wb_bus = {gr_we, dest, final_result, pc};

    assign mem_if.mem_allowin       = mem_allowin;
    assign mem_if.mem_to_wb_valid   = valid & mem_ready_go;
    assign mem_if.mem_to_wb_bus     = wb_bus;
    assign mem_if.mem_to_wb_csr_bus = csr_q;
    assign mem_if.mem_ex_out        = valid & (|csr_q[2:0]);
    assign mem_if.gr_we_mem         = valid & gr_we;
    assign mem_if.dest_mem          = valid ? dest : 5'd0;
    assign mem_if.forward_data_mem  = valid ? final_result : 32'd0;
    assign mem_if.mem_load_pending  = valid & load_op & ~mem_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios, then a randomized run against a
// transaction-level model of the stage and an in-order data SRAM.
module tb_mem_stage;
    localparam int unsigned EW = 78;
    localparam int unsigned CW = 96;
    localparam int unsigned MW = 70;

    localparam int OpAlu  = 0;
    localparam int OpLdB  = 1;
    localparam int OpLdBu = 2;
    localparam int OpLdH  = 3;
    localparam int OpLdHu = 4;
    localparam int OpLdW  = 5;
    localparam int OpSt   = 6;

    typedef struct {
        int          op;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] pc;
        logic [CW-1:0] csr;
        logic        req;
        logic        has_data;
        logic [31:0] data;
    } rec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_pass = 0;

    mem_stage_if #(.EXE_TO_MEM_BUS_WD(EW), .CSR_BUS_WD(CW), .MEM_TO_WB_BUS_WD(MW)) mif ();

    mem_stage #(.EXE_TO_MEM_BUS_WD(EW), .CSR_BUS_WD(CW), .MEM_TO_WB_BUS_WD(MW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mem_if (mif)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] make_bus(input int op, input logic [31:0] alu,
                                               input logic [4:0] dest, input logic gr_we,
                                               input logic [31:0] pc);
        logic [EW-1:0] b;
        b        = '0;
        b[77]    = (op == OpLdB);
        b[76]    = (op == OpLdBu);
        b[75]    = (op == OpLdH);
        b[74]    = (op == OpLdHu);
        b[73]    = (op == OpLdW);
        b[72]    = (op == OpLdB) || (op == OpLdH);
        b[70]    = (op >= OpLdB) && (op <= OpLdW);
        b[69]    = gr_we;
        b[68:64] = dest;
        b[63:32] = alu;
        b[31:0]  = pc;
        return b;
    endfunction

    // Expected architectural result from the load rules, in plain arithmetic.
    function automatic logic [31:0] ref_result(input int op, input logic [31:0] alu,
                                               input logic [31:0] rdata);
        int unsigned a, b, h;
        a = alu % 4;
        b = (rdata >> (8 * a)) & 32'hff;
        h = (rdata >> (16 * (a / 2))) & 32'hffff;
        case (op)
            OpLdB:   return (b >= 128) ? b + 32'hffff_ff00 : b;
            OpLdBu:  return b;
            OpLdH:   return (h >= 32768) ? h + 32'hffff_0000 : h;
            OpLdHu:  return h;
            OpLdW:   return rdata;
            default: return alu;
        endcase
    endfunction

    task automatic set_idle();
        mif.exe_to_mem_valid   = 1'b0;
        mif.exe_to_mem_bus     = '0;
        mif.exe_to_mem_csr_bus = '0;
        mif.exe_to_mem_req     = 1'b0;
        mif.wb_allowin         = 1'b1;
        mif.wb_flush           = 1'b0;
        mif.data_sram_data_ok  = 1'b0;
        mif.data_sram_rdata    = '0;
    endtask

    task automatic issue(input int op, input logic [31:0] alu, input logic [4:0] dest,
                         input logic gr_we, input logic [CW-1:0] csr);
        mif.exe_to_mem_valid   = 1'b1;
        mif.exe_to_mem_bus     = make_bus(op, alu, dest, gr_we, 32'h1c00_0100);
        mif.exe_to_mem_csr_bus = csr;
        mif.exe_to_mem_req     = (op != OpAlu);
    endtask

    task automatic test_reset();
        set_idle();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", mif.mem_allowin);
        else n_pass++;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", mif.mem_to_wb_valid);
        else n_pass++;
        n_checks++;
        if (mif.mem_to_wb_bus !== '0) $display("FAIL reset_bus: got %h want 0", mif.mem_to_wb_bus);
        else n_pass++;
        n_checks++;
        if (mif.mem_to_wb_csr_bus !== '0) $display("FAIL reset_csr: got %h want 0", mif.mem_to_wb_csr_bus);
        else n_pass++;
        n_checks++;
        if ({mif.mem_ex_out, mif.gr_we_mem, mif.dest_mem, mif.mem_load_pending} !== 8'd0)
            $display("FAIL reset_side: got %b want 0",
                     {mif.mem_ex_out, mif.gr_we_mem, mif.dest_mem, mif.mem_load_pending});
        else n_pass++;
        n_checks++;
        if (mif.forward_data_mem !== 32'd0) $display("FAIL reset_fwd: got %h want 0", mif.forward_data_mem);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_load_byte();
        @(negedge clk); set_idle(); issue(OpLdB, 32'h1000_0003, 5'd3, 1'b1, '0); #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b1) $display("FAIL ldb_accept: got %b want 1", mif.mem_allowin);
        else n_pass++;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_load_pending !== 1'b1) $display("FAIL ldb_pending: got %b want 1", mif.mem_load_pending);
        else n_pass++;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL ldb_early: got %b want 0", mif.mem_to_wb_valid);
        else n_pass++;
        @(negedge clk); mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'h80FF_FF00; #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL ldb_valid: got %b want 1", mif.mem_to_wb_valid);
        else n_pass++;
        n_checks++;
        if (mif.mem_to_wb_bus[63:32] !== 32'hFFFF_FF80)
            $display("FAIL ldb_result: got %h want ffffff80", mif.mem_to_wb_bus[63:32]);
        else n_pass++;
        n_checks++;
        if (mif.mem_load_pending !== 1'b0) $display("FAIL ldb_pend_clr: got %b want 0", mif.mem_load_pending);
        else n_pass++;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL ldb_leave: got %b want 0", mif.mem_to_wb_valid);
        else n_pass++;
    endtask

    task automatic test_buffered_half();
        @(negedge clk); set_idle(); issue(OpLdHu, 32'h1000_0002, 5'd4, 1'b1, '0);
        @(negedge clk); set_idle();
        mif.wb_allowin = 1'b0; mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'hBEEF_1234; #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b0) $display("FAIL buf_stall: got %b want 0", mif.mem_allowin);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_idle(); mif.wb_allowin = 1'b0;
            if (i == 1) begin
                mif.data_sram_data_ok = 1'b1;
                mif.data_sram_rdata   = 32'h5555_5555;
            end
            #1;
            n_checks++;
            if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[63:32] !== 32'h0000_BEEF)
                $display("FAIL buf_hold%0d: got %b/%h want 1/0000beef", i,
                         mif.mem_to_wb_valid, mif.mem_to_wb_bus[63:32]);
            else n_pass++;
        end
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[63:32] !== 32'h0000_BEEF)
            $display("FAIL buf_release: got %b/%h want 1/0000beef",
                     mif.mem_to_wb_valid, mif.mem_to_wb_bus[63:32]);
        else n_pass++;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL buf_leave: got %b want 0", mif.mem_to_wb_valid);
        else n_pass++;
    endtask

    task automatic test_alu_op();
        @(negedge clk); set_idle(); issue(OpAlu, 32'h0000_0042, 5'd7, 1'b1, '0);
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL alu_valid: got %b want 1", mif.mem_to_wb_valid);
        else n_pass++;
        n_checks++;
        if (mif.forward_data_mem !== 32'h42) $display("FAIL alu_fwd: got %h want 42", mif.forward_data_mem);
        else n_pass++;
        n_checks++;
        if (mif.gr_we_mem !== 1'b1 || mif.dest_mem !== 5'd7)
            $display("FAIL alu_dest: got %b/%0d want 1/7", mif.gr_we_mem, mif.dest_mem);
        else n_pass++;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.dest_mem !== 5'd0) $display("FAIL alu_dest_clr: got %0d want 0", mif.dest_mem);
        else n_pass++;
    endtask

    task automatic test_flush_discard();
        @(negedge clk); set_idle(); issue(OpLdW, 32'h2000_0000, 5'd5, 1'b1, '0);
        @(negedge clk); set_idle(); mif.wb_flush = 1'b1;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b1) $display("FAIL fl_killed: got %b want 1", mif.mem_allowin);
        else n_pass++;
        @(negedge clk); set_idle(); issue(OpLdW, 32'h2000_0004, 5'd6, 1'b1, '0);
        @(negedge clk); set_idle(); mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'h1111_1111; #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b0 || mif.mem_load_pending !== 1'b1)
            $display("FAIL fl_drop: got %b/%b want 0/1", mif.mem_to_wb_valid, mif.mem_load_pending);
        else n_pass++;
        @(negedge clk); mif.data_sram_rdata = 32'h2222_2222; #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[63:32] !== 32'h2222_2222)
            $display("FAIL fl_deliver: got %b/%h want 1/22222222",
                     mif.mem_to_wb_valid, mif.mem_to_wb_bus[63:32]);
        else n_pass++;
        @(negedge clk); set_idle(); issue(OpLdW, 32'h2000_0008, 5'd6, 1'b1, '0);
        @(negedge clk); set_idle(); mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'h3333_3333; #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[63:32] !== 32'h3333_3333)
            $display("FAIL fl_cnt_zero: got %b/%h want 1/33333333",
                     mif.mem_to_wb_valid, mif.mem_to_wb_bus[63:32]);
        else n_pass++;
        // Flush must beat an accept offered in the same cycle.
        @(negedge clk); set_idle(); issue(OpAlu, 32'h55, 5'd4, 1'b1, '0);
        @(negedge clk); set_idle(); issue(OpAlu, 32'h66, 5'd5, 1'b1, '0); mif.wb_flush = 1'b1; #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b1) $display("FAIL fl_allow: got %b want 1", mif.mem_allowin);
        else n_pass++;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b0 || mif.dest_mem !== 5'd0)
            $display("FAIL fl_no_latch: got %b/%0d want 0/0", mif.mem_to_wb_valid, mif.dest_mem);
        else n_pass++;
    endtask

    task automatic test_store_ex();
        logic [CW-1:0] csr;
        csr      = {$urandom(), $urandom(), $urandom()};
        csr[2:0] = 3'b001;
        @(negedge clk); set_idle(); issue(OpSt, 32'h3000_0010, 5'd0, 1'b0, csr); #1;
        n_checks++;
        if (mif.mem_ex_out !== 1'b0) $display("FAIL st_ex_early: got %b want 0", mif.mem_ex_out);
        else n_pass++;
        @(negedge clk); set_idle(); mif.exe_to_mem_csr_bus = ~csr; #1;
        n_checks++;
        if (mif.mem_ex_out !== 1'b1) $display("FAIL st_ex: got %b want 1", mif.mem_ex_out);
        else n_pass++;
        n_checks++;
        if (mif.mem_to_wb_csr_bus !== csr) $display("FAIL st_csr: got %h want %h", mif.mem_to_wb_csr_bus, csr);
        else n_pass++;
        n_checks++;
        if (mif.mem_load_pending !== 1'b0 || mif.mem_to_wb_valid !== 1'b0)
            $display("FAIL st_wait: got %b/%b want 0/0", mif.mem_load_pending, mif.mem_to_wb_valid);
        else n_pass++;
        @(negedge clk); mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = $urandom(); #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[63:32] !== 32'h3000_0010)
            $display("FAIL st_result: got %b/%h want 1/30000010",
                     mif.mem_to_wb_valid, mif.mem_to_wb_bus[63:32]);
        else n_pass++;
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_ex_out !== 1'b0) $display("FAIL st_ex_clr: got %b want 0", mif.mem_ex_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); set_idle(); issue(OpLdW, 32'h4000_0000, 5'd8, 1'b1, '0);
        @(negedge clk); set_idle(); mif.wb_flush = 1'b1;
        @(negedge clk); set_idle(); issue(OpLdW, 32'h4000_0004, 5'd8, 1'b1, '0);
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_load_pending !== 1'b1) $display("FAIL rw_wait: got %b want 1", mif.mem_load_pending);
        else n_pass++;
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b1 || mif.mem_load_pending !== 1'b0)
            $display("FAIL rw_async: got %b/%b want 1/0", mif.mem_allowin, mif.mem_load_pending);
        else n_pass++;
        @(negedge clk); resetn = 1'b1; issue(OpLdW, 32'h4000_0008, 5'd9, 1'b1, '0);
        @(negedge clk); set_idle(); mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'hDEAD_BEEF; #1;
        n_checks++;
        if (mif.mem_to_wb_valid !== 1'b1 || mif.mem_to_wb_bus[63:32] !== 32'hDEAD_BEEF)
            $display("FAIL rw_after: got %b/%h want 1/deadbeef",
                     mif.mem_to_wb_valid, mif.mem_to_wb_bus[63:32]);
        else n_pass++;
        @(negedge clk); set_idle();
    endtask

    task automatic test_random();
        rec_t        q[$];
        rec_t        r;
        int          sram_pend;
        int          orphans;
        logic        dok, flush, exp_valid, exp_allow, exp_pend, exp_ex;
        logic [31:0] exp_res;
        sram_pend = 0;
        orphans   = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            set_idle();
            dok = (sram_pend > 0) && ((c >= 2960) || ($urandom_range(1, 0) == 1));
            mif.data_sram_data_ok = dok;
            mif.data_sram_rdata   = $urandom();
            if (c < 2960) begin
                mif.wb_allowin = ($urandom_range(9, 0) < 7);
                flush          = (orphans == 0) && ($urandom_range(19, 0) == 0);
                r.op       = $urandom_range(6, 0);
                r.alu      = $urandom();
                r.dest     = 5'($urandom_range(31, 0));
                r.gr_we    = (r.op != OpSt);
                r.pc       = $urandom();
                r.csr      = {$urandom(), $urandom(), $urandom()};
                r.csr[2:0] = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
                r.req      = (r.op != OpAlu);
                r.has_data = 1'b0;
                r.data     = '0;
                mif.exe_to_mem_valid   = ($urandom_range(9, 0) < 7);
                mif.exe_to_mem_bus     = make_bus(r.op, r.alu, r.dest, r.gr_we, r.pc);
                mif.exe_to_mem_csr_bus = r.csr;
                mif.exe_to_mem_req     = r.req;
            end else begin
                flush = 1'b0;
            end
            mif.wb_flush = flush;
            #1;
            if (dok) begin
                sram_pend--;
                if (orphans > 0) orphans--;
                else if (q.size() > 0) begin
                    q[0].has_data = 1'b1;
                    q[0].data     = mif.data_sram_rdata;
                end
            end
            exp_valid = (q.size() > 0) && (!q[0].req || q[0].has_data);
            exp_allow = (q.size() == 0) || (exp_valid && mif.wb_allowin);
            exp_pend  = (q.size() > 0) && (q[0].op >= OpLdB) && (q[0].op <= OpLdW) && !exp_valid;
            exp_ex    = (q.size() > 0) && (q[0].csr[2:0] != 3'b000);
            n_checks++;
            if (mif.mem_to_wb_valid !== exp_valid || mif.mem_allowin !== exp_allow)
                $display("FAIL rnd_hs c=%0d: got %b/%b want %b/%b", c,
                         mif.mem_to_wb_valid, mif.mem_allowin, exp_valid, exp_allow);
            else n_pass++;
            n_checks++;
            if (mif.mem_load_pending !== exp_pend || mif.mem_ex_out !== exp_ex)
                $display("FAIL rnd_side c=%0d: got %b/%b want %b/%b", c,
                         mif.mem_load_pending, mif.mem_ex_out, exp_pend, exp_ex);
            else n_pass++;
            if (exp_valid) begin
                exp_res = ref_result(q[0].op, q[0].alu, q[0].data);
                n_checks++;
                if (mif.mem_to_wb_bus !== {q[0].gr_we, q[0].dest, exp_res, q[0].pc} ||
                    mif.forward_data_mem !== exp_res || mif.mem_to_wb_csr_bus !== q[0].csr)
                    $display("FAIL rnd_data c=%0d op=%0d: got %h/%h want %h/%h", c, q[0].op,
                             mif.mem_to_wb_bus, mif.forward_data_mem,
                             {q[0].gr_we, q[0].dest, exp_res, q[0].pc}, exp_res);
                else n_pass++;
            end
            if (flush) begin
                if (q.size() > 0) begin
                    if (q[0].req && !q[0].has_data) orphans++;
                    void'(q.pop_front());
                end
            end else begin
                if (exp_valid && mif.wb_allowin) void'(q.pop_front());
                if (mif.exe_to_mem_valid && exp_allow) begin
                    q.push_back(r);
                    if (r.req) sram_pend++;
                end
            end
        end
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (mif.mem_allowin !== 1'b1 || mif.mem_to_wb_valid !== 1'b0)
            $display("FAIL rnd_drain: got %b/%b want 1/0", mif.mem_allowin, mif.mem_to_wb_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_buffered_half();
        test_alu_op();
        test_flush_discard();
        test_store_ex();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the LoongArch core, directly downstream of EXE and upstream of WB.
- Latches the EXE→MEM bus and waits for the data-SRAM response (data_ok) to any load/store that EXE issued.
- Extracts and sign/zero-extends load data, provides forwarding and stall information to decode, and passes the result to WB.
- Drops SRAM responses orphaned by a WB flush.

Parameters:
- EXE_TO_MEM_BUS_WD, 78, width of EXE→MEM bus. Fields: ld_b[77], ld_bu[76], ld_h[75], ld_hu[74], ld_w[73], signed_option[72], lu12i_w[71], load_op[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0].
- CSR_BUS_WD, 96, width of opaque CSR/exception sideband. Bit 0 = ex flag, bit 1 = ertn, bit 2 = refetch; the rest pass through.
- MEM_TO_WB_BUS_WD, 70, output bus: gr_we[69], dest[68:64], final_result[63:32], pc[31:0].

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- exe_to_mem_valid  in  1  EXE has an instruction ready
- exe_to_mem_bus  in  EXE_TO_MEM_BUS_WD  instruction payload
- exe_to_mem_csr_bus  in  CSR_BUS_WD  CSR/exception sideband
- exe_to_mem_req  in  1  instruction issued a data-SRAM request (addr_ok accepted in EXE)
- mem_allowin  out  1  MEM can accept from EXE
- wb_allowin  in  1  WB can accept
- wb_flush  in  1  exception/ertn/refetch committed in WB; kills MEM
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  response data
- mem_to_wb_valid  out  1  instruction leaving MEM
- mem_to_wb_bus  out  MEM_TO_WB_BUS_WD  result payload
- mem_to_wb_csr_bus  out  CSR_BUS_WD  registered sideband
- mem_ex_out  out  1  valid & (ex|ertn|refetch) in MEM; used by EXE to kill store strobes
- gr_we_mem  out  1  valid & gr_we
- dest_mem  out  5  dest when valid, else 0
- forward_data_mem  out  32  final_result when valid, else 0
- mem_load_pending  out  1  valid & load_op & result not yet available; decode must stall dependants

Behaviour:
- Async reset (resetn=0): valid=0, state=EMPTY, bus/sideband regs=0, data_buf=0, discard_cnt=0. All outputs therefore 0, except mem_allowin=1.
- State machine:
  - EMPTY: valid=0.
  - WAIT: valid, request outstanding, no data yet.
  - READY: valid, result available.
- Accept: exe_to_mem_valid & mem_allowin. Next state is WAIT if exe_to_mem_req, else READY.
- mem_ready_go = (state==READY) | (state==WAIT & data_sram_data_ok & discard_cnt==0).
- mem_allowin = !valid | (mem_ready_go & wb_allowin).
- mem_to_wb_valid = valid & mem_ready_go.
- WAIT & data_ok & discard_cnt==0 & !wb_allowin: capture rdata into data_buf and go to READY.
- In READY the result uses data_buf. Same-cycle data_ok with wb_allowin passes rdata combinationally (zero extra latency).
- Load extraction uses addr[1:0] = alu_result[1:0]:
  - ld_b: sign-extend byte at addr[1:0]. ld_bu: zero-extend that byte.
  - ld_h: sign-extend half at addr[1]. ld_hu: zero-extend that half.
  - ld_w: full word.
- final_result = load_op ? extracted : alu_result. Stores also wait for data_ok but produce alu_result.
- wb_flush has priority over accept:
  - valid clears next cycle.
  - If the state is WAIT and data_ok is not in this cycle, discard_cnt increments. It saturates at 3.
  - An incoming instruction in the same cycle is not latched.
- data_ok while discard_cnt!=0 is consumed and discard_cnt decrements. It is never delivered to any instruction; a new instruction stays in WAIT.
- Simultaneous discard decrement and new-orphan increment leave discard_cnt unchanged.
- mem_ex_out ignores state; asserted immediately on valid.
- Bus and sideband registers load only on accept; they hold otherwise.

Test Plan:
- ld_b, alu_result=0x1000_0003, exe_to_mem_req=1; data_ok one cycle later with rdata=0x80FF_FF00 → final_result=0xFFFF_FF80, mem_to_wb_valid in the data_ok cycle; mem_load_pending=1 before it.
- ld_hu at addr 0x…2, rdata=0xBEEF_1234, wb_allowin=0 during data_ok for 3 cycles → data_buf holds the value, state READY, output 0x0000_BEEF once wb_allowin=1; no second data_ok consumed.
- Non-memory add, alu_result=0x42, exe_to_mem_req=0 → mem_to_wb_valid the cycle after accept; forward_data_mem=0x42; gr_we_mem=1.
- Load in WAIT, wb_flush pulse, then a new load accepted, then two data_ok (0x1111_1111 then 0x2222_2222) → the first is discarded, the new load returns 0x2222_2222; discard_cnt returns to 0.
- Store, exe_to_mem_csr_bus[0]=1 → mem_ex_out=1 on the valid cycle; store result equals alu_result; sideband copied to mem_to_wb_csr_bus unchanged.
- resetn deasserted mid-WAIT → valid=0, discard_cnt=0, mem_allowin=1 immediately (async); a following ld_w with rdata=0xDEAD_BEEF returns 0xDEAD_BEEF.
